// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer for a single-port sync RAM: grant same cycle as req, read data 1 cycle after grant.
// Losing/locked-out port holds req until gnt; RAM_ARB_ROUND_ROBIN_EN selects round-robin, else port 1 has priority.
module ram_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_write_enable,
  input  logic [DATA_W-1:0] ram_data_out
);

  typedef enum logic [1:0] {OPEN, OWN0, OWN1} lock_state_t;

  lock_state_t       state_q, state_d;
  logic              rd_pend_q, rd_port_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] rdata_q;
  logic              pick1;
  logic              rd_issue;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic last_q;
  // last_q holds the most recently granted port; the other one wins a tie
  assign pick1 = (last_q == 1'b0);
`else
  assign pick1 = 1'b1;
`endif

  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_d = state_q;
    case (state_q)
      OWN0: begin
        gnt0 = req0;
        if (!req0 || !lock0) state_d = OPEN;
      end
      OWN1: begin
        gnt1 = req1;
        if (!req1 || !lock1) state_d = OPEN;
      end
      default: begin
        if (req0 && req1) begin
          gnt1 = pick1;
          gnt0 = !pick1;
        end else begin
          gnt0 = req0;
          gnt1 = req1;
        end
        if (gnt0 && lock0)      state_d = OWN0;
        else if (gnt1 && lock1) state_d = OWN1;
      end
    endcase
    if (!rst_n) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  assign ram_addr         = gnt1 ? addr1  : (gnt0 ? addr0  : addr_q);
  assign ram_data_in      = gnt1 ? wdata1 : (gnt0 ? wdata0 : '0);
  assign ram_write_enable = (gnt0 & we0) | (gnt1 & we1);
  assign rd_issue         = (gnt0 & ~we0) | (gnt1 & ~we1);

  assign rvalid0 = rd_pend_q & ~rd_port_q;
  assign rvalid1 = rd_pend_q & rd_port_q;
  assign rdata   = rd_pend_q ? ram_data_out : rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= OPEN;
      rd_pend_q <= 1'b0;
      rd_port_q <= 1'b0;
      addr_q    <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= rd_issue;
      addr_q    <= ram_addr;
      if (rd_issue)  rd_port_q <= gnt1;
      if (rd_pend_q) rdata_q   <= ram_data_out;
    end
  end

`ifdef RAM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           last_q <= 1'b0;
    else if (gnt0 | gnt1) last_q <= gnt1;
  end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: scripted scenarios plus randomized traffic against a rule-level model.
module tb_ram_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0, lock0 = 0, lock1 = 0;
  logic [8:0]  addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, ram_write_enable;
  logic [31:0] rdata, ram_data_in;
  logic [8:0]  ram_addr;
  logic [31:0] ram_data_out = '0;

  logic [31:0] ram_mem [512];
  logic [31:0] ref_mem [512];

  int checks = 0;
  int failures = 0;

  // reference model state
  int          m_owner;   // 0 none, 1 port0 owns, 2 port1 owns
  int          m_last;    // last granted port
  bit          m_pend;
  int          m_pport;
  logic [31:0] m_rdata;
  logic [8:0]  m_addr;
  // expectations for the current cycle
  bit          e_g0, e_g1, e_we;
  logic [8:0]  e_addr;
  logic [31:0] e_din;

  ram_arbiter #(.ADDR_W(9), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1), .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_write_enable(ram_write_enable),
    .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  // 512x32 single-port RAM with registered output
  always @(posedge clk) begin
    if (ram_write_enable) ram_mem[ram_addr] <= ram_data_in;
    ram_data_out <= ram_mem[ram_addr];
  end

  task automatic model_reset();
    m_owner = 0; m_last = 0; m_pend = 0; m_pport = 0; m_rdata = '0; m_addr = '0;
  endtask

  task automatic model_eval();
    int winner;
    e_g0 = 0; e_g1 = 0;
    if (rst_n) begin
      if (m_owner == 1) e_g0 = req0;
      else if (m_owner == 2) e_g1 = req1;
      else if (req0 && req1) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
        winner = (m_last == 0) ? 1 : 0;
`else
        winner = 1;
`endif
        e_g0 = (winner == 0);
        e_g1 = (winner == 1);
      end else begin
        e_g0 = req0;
        e_g1 = req1;
      end
    end
    e_we   = (e_g0 && we0) || (e_g1 && we1);
    e_addr = e_g1 ? addr1 : (e_g0 ? addr0 : m_addr);
    e_din  = e_g1 ? wdata1 : (e_g0 ? wdata0 : 32'h0);
  endtask

  task automatic model_commit();
    bit p, w, lk;
    m_pend = 0;
    if (e_g0 || e_g1) begin
      p  = e_g1;
      w  = p ? we1 : we0;
      lk = p ? lock1 : lock0;
      m_last = int'(p);
      m_addr = e_addr;
      if (w) ref_mem[e_addr] = e_din;
      else begin
        m_pend = 1; m_pport = int'(p); m_rdata = ref_mem[e_addr];
      end
      if (m_owner == 0 && lk) m_owner = int'(p) + 1;
      else if (m_owner != 0 && !lk) m_owner = 0;
    end else begin
      m_owner = 0;
    end
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic next_cycle();
    model_commit();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive0(bit r, bit w, bit l, logic [8:0] a, logic [31:0] d);
    req0 = r; we0 = w; lock0 = l; addr0 = a; wdata0 = d;
  endtask

  task automatic drive1(bit r, bit w, bit l, logic [8:0] a, logic [31:0] d);
    req1 = r; we1 = w; lock1 = l; addr1 = a; wdata1 = d;
  endtask

  task automatic do_reset();
    rst_n = 0;
    drive0(0, 0, 0, '0, '0); drive1(0, 0, 0, '0, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    model_reset();
    drive0(1, 1, 1, 9'h055, 32'hA5A5A5A5); drive1(1, 1, 1, 9'h0AA, 32'h5A5A5A5A);
    #2;
    checks++; if ({gnt0, gnt1} !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", {gnt0, gnt1}); end
    checks++; if ({rvalid0, rvalid1, ram_write_enable} !== 3'b000) begin failures++; $display("FAIL reset_rv_we got=%b exp=000", {rvalid0, rvalid1, ram_write_enable}); end
    checks++; if (rdata !== 32'h0 || ram_addr !== 9'h0) begin failures++; $display("FAIL reset_data got rdata=%h addr=%h exp 0/0", rdata, ram_addr); end
    @(negedge clk);
    drive0(0, 0, 0, '0, '0); drive1(0, 0, 0, '0, '0);
    rst_n = 1;
    next_cycle();
  endtask

  task automatic test_single_read();
    ram_mem[9'h010] = 32'hDEADBEEF; ref_mem[9'h010] = 32'hDEADBEEF;
    drive0(1, 0, 0, 9'h010, '0);
    settle();
    checks++; if ({gnt0, gnt1} !== 2'b10) begin failures++; $display("FAIL single_gnt got=%b exp=10", {gnt0, gnt1}); end
    checks++; if (ram_addr !== 9'h010 || ram_write_enable !== 1'b0) begin failures++; $display("FAIL single_ram got addr=%h we=%b exp 010/0", ram_addr, ram_write_enable); end
    next_cycle();
    drive0(0, 0, 0, '0, '0);
    settle();
    checks++; if ({rvalid0, rvalid1} !== 2'b10) begin failures++; $display("FAIL single_rvalid got=%b exp=10", {rvalid0, rvalid1}); end
    checks++; if (rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL single_rdata got=%h exp=deadbeef", rdata); end
    next_cycle();
    settle();
    checks++; if (rvalid0 !== 1'b0 || rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL single_hold got rv=%b rdata=%h exp 0/deadbeef", rvalid0, rdata); end
  endtask

  task automatic test_write_read();
    drive1(1, 1, 0, 9'h1FF, 32'h12345678);
    settle();
    checks++; if (gnt1 !== 1'b1 || ram_write_enable !== 1'b1 || ram_data_in !== 32'h12345678) begin failures++; $display("FAIL wr_issue got gnt1=%b we=%b din=%h exp 1/1/12345678", gnt1, ram_write_enable, ram_data_in); end
    next_cycle();
    drive1(1, 0, 0, 9'h1FF, '0);
    settle();
    checks++; if (gnt1 !== 1'b1 || ram_write_enable !== 1'b0 || rvalid1 !== 1'b0) begin failures++; $display("FAIL rd_issue got gnt1=%b we=%b rv1=%b exp 1/0/0", gnt1, ram_write_enable, rvalid1); end
    next_cycle();
    drive1(0, 0, 0, '0, '0);
    settle();
    checks++; if (rvalid1 !== 1'b1 || rvalid0 !== 1'b0 || rdata !== 32'h12345678) begin failures++; $display("FAIL raw_rdata got rv1=%b rv0=%b rdata=%h exp 1/0/12345678", rvalid1, rvalid0, rdata); end
    next_cycle();
  endtask

  task automatic test_contention();
    int exp_seq [8];
    int left0 = 4, left1 = 4, idx = 0, c = 0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    exp_seq = '{1, 0, 1, 0, 1, 0, 1, 0};
`else
    exp_seq = '{1, 1, 1, 1, 0, 0, 0, 0};
`endif
    do_reset();
    while ((left0 > 0 || left1 > 0) && c < 20) begin
      drive0(left0 > 0, 0, 0, 9'(9'h020 + left0), '0);
      drive1(left1 > 0, 0, 0, 9'(9'h040 + left1), '0);
      settle();
      checks++; if (rdata !== m_rdata || {rvalid0, rvalid1} !== {m_pend && m_pport == 0, m_pend && m_pport == 1}) begin failures++; $display("FAIL cont_rdata cyc=%0d got rv=%b%b rdata=%h exp rdata=%h", c, rvalid0, rvalid1, rdata, m_rdata); end
      checks++; if (idx > 7 || {gnt0, gnt1} !== {exp_seq[idx] == 0, exp_seq[idx] == 1}) begin failures++; $display("FAIL cont_order step=%0d got gnt0=%b gnt1=%b exp port %0d", idx, gnt0, gnt1, (idx > 7) ? -1 : exp_seq[idx]); end
      if (e_g0) left0--;
      if (e_g1) left1--;
      if (e_g0 || e_g1) idx++;
      c++;
      next_cycle();
    end
    checks++; if (left0 != 0 || left1 != 0) begin failures++; $display("FAIL cont_timeout got left0=%0d left1=%0d exp 0/0", left0, left1); end
    drive0(0, 0, 0, '0, '0); drive1(0, 0, 0, '0, '0);
    settle();
    next_cycle();
  endtask

  task automatic test_lock();
    for (int c = 0; c < 4; c++) begin
      drive0(1, 0, 0, 9'h030, '0);
      drive1(c < 3, 1, c < 2, 9'(9'h100 + c), 32'(32'hC0DE0000 + c));
      settle();
      checks++; if (gnt0 !== (c == 3) || gnt1 !== (c < 3)) begin failures++; $display("FAIL lock_cyc%0d got gnt0=%b gnt1=%b exp %b/%b", c, gnt0, gnt1, c == 3, c < 3); end
      next_cycle();
    end
    drive0(0, 0, 0, '0, '0); drive1(0, 0, 0, '0, '0);
    settle();
    checks++; if (rvalid0 !== 1'b1 || rdata !== ref_mem[9'h030]) begin failures++; $display("FAIL lock_rdata got rv0=%b rdata=%h exp 1/%h", rvalid0, rdata, ref_mem[9'h030]); end
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    drive0(1, 0, 0, 9'h010, '0);
    settle();
    checks++; if (gnt0 !== 1'b1) begin failures++; $display("FAIL rst_mid_gnt got=%b exp=1", gnt0); end
    model_commit();
    @(posedge clk);
    rst_n = 0;
    model_reset();
    drive0(1, 0, 0, 9'h011, '0);
    #1;
    checks++; if ({rvalid0, rvalid1, gnt0, gnt1, ram_write_enable} !== 5'b0) begin failures++; $display("FAIL rst_mid_ctl got=%b exp=00000", {rvalid0, rvalid1, gnt0, gnt1, ram_write_enable}); end
    checks++; if (rdata !== 32'h0 || ram_addr !== 9'h0) begin failures++; $display("FAIL rst_mid_data got rdata=%h addr=%h exp 0/0", rdata, ram_addr); end
    @(negedge clk);
    checks++; if (rvalid0 !== 1'b0 || gnt0 !== 1'b0) begin failures++; $display("FAIL rst_mid_hold got rv0=%b gnt0=%b exp 0/0", rvalid0, gnt0); end
    rst_n = 1;
    drive0(0, 0, 0, '0, '0);
    drive1(1, 0, 0, 9'h1FF, '0);
    settle();
    checks++; if ({gnt0, gnt1} !== 2'b01) begin failures++; $display("FAIL rst_after_gnt got=%b exp=01", {gnt0, gnt1}); end
    next_cycle();
    drive1(0, 0, 0, '0, '0);
    settle();
    checks++; if (rvalid1 !== 1'b1 || rdata !== 32'h12345678) begin failures++; $display("FAIL rst_after_rd got rv1=%b rdata=%h exp 1/12345678", rvalid1, rdata); end
    next_cycle();
  endtask

  task automatic test_idle();
    logic [8:0] a0;
    drive0(0, 0, 0, 9'h0AB, '0); drive1(0, 0, 0, 9'h0CD, '0);
    settle();
    a0 = m_addr;
    for (int c = 0; c < 10; c++) begin
      checks++; if ({gnt0, gnt1, rvalid0, rvalid1, ram_write_enable} !== 5'b0 || ram_addr !== a0) begin failures++; $display("FAIL idle_cyc%0d got ctl=%b addr=%h exp 00000/%h", c, {gnt0, gnt1, rvalid0, rvalid1, ram_write_enable}, ram_addr, a0); end
      next_cycle();
      settle();
    end
  endtask

  function automatic logic [8:0] pick_addr();
    if ($urandom_range(0, 1) == 0) return 9'(9'h0E0 + $urandom_range(0, 3));
    return 9'($urandom_range(0, 511));
  endfunction

  task automatic test_random();
    bit h0 = 0, h1 = 0;
    for (int c = 0; c < 400; c++) begin
      if (!h0) drive0($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, pick_addr(), $urandom);
      if (!h1) drive1($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, pick_addr(), $urandom);
      settle();
      checks++; if (gnt0 !== e_g0 || gnt1 !== e_g1) begin failures++; $display("FAIL rand_gnt cyc=%0d got=%b%b exp=%b%b", c, gnt0, gnt1, e_g0, e_g1); end
      checks++; if (ram_write_enable !== e_we || ram_addr !== e_addr || ram_data_in !== e_din) begin failures++; $display("FAIL rand_ram cyc=%0d got we=%b addr=%h din=%h exp %b/%h/%h", c, ram_write_enable, ram_addr, ram_data_in, e_we, e_addr, e_din); end
      checks++; if (rvalid0 !== (m_pend && m_pport == 0) || rvalid1 !== (m_pend && m_pport == 1) || rdata !== m_rdata) begin failures++; $display("FAIL rand_rd cyc=%0d got rv=%b%b rdata=%h exp rv=%b%b rdata=%h", c, rvalid0, rvalid1, rdata, m_pend && m_pport == 0, m_pend && m_pport == 1, m_rdata); end
      h0 = req0 && !e_g0;
      h1 = req1 && !e_g1;
      next_cycle();
    end
    drive0(0, 0, 0, '0, '0); drive1(0, 0, 0, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      ram_mem[i] = $urandom;
      ref_mem[i] = ram_mem[i];
    end
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_lock();
    test_reset_mid_read();
    test_idle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
